rr_requester: RTL and testbench



---
 rtl/rr_requester.sv | 105 ++++++++++
 tb/tb_rr_requester.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_requester.sv
// rtl/rr_requester.sv - FIFO-buffered round-robin bus requester with bounded bursts
module rr_requester #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int BURST = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DW-1:0]                in_data_i,
    output logic                         req_o,
    input  logic                         grant_i,
    output logic                         bus_valid_o,
    output logic [DW-1:0]                bus_data_o,
    output logic                         bus_last_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic [DW-1:0]   mem_q [DEPTH];
    logic            push, pop;

    assign in_ready_o  = (level_q != LW'(DEPTH));
    assign push        = in_valid_i & in_ready_o;
    assign req_o       = (state_q == S_REQ);
    assign bus_valid_o = req_o & grant_i;
    assign pop         = bus_valid_o;
    assign bus_data_o  = mem_q[rd_ptr_q];
    assign level_o     = level_q;
    // Pre-update level: a word pushed during the final beat waits for the next burst.
    assign bus_last_o  = bus_valid_o & ((beat_cnt_q == BW'(BURST - 1)) | (level_q == LW'(1)));

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        level_d    = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    state_d    = S_REQ;
                    beat_cnt_d = '0;
                end
            end
            S_REQ: begin
                if (bus_last_o) begin
                    state_d = S_GAP;
                end else if (bus_valid_o) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                state_d    = (level_q != '0) ? S_REQ : S_IDLE;
                beat_cnt_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            level_q    <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_rr_requester.sv
// tb/tb_rr_requester.sv - self-checking bench for rr_requester
module tb_rr_requester;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int BURST = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          req;
    logic          grant;
    logic          bus_valid;
    logic [DW-1:0] bus_data;
    logic          bus_last;
    logic [2:0]    level;

    rr_requester #(.DW(DW), .DEPTH(DEPTH), .BURST(BURST)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .req_o       (req),
        .grant_i     (grant),
        .bus_valid_o (bus_valid),
        .bus_data_o  (bus_data),
        .bus_last_o  (bus_last),
        .level_o     (level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: the queue holds the words; requesting flag plus beats taken in this burst.
    logic [7:0] mq[$];
    bit         m_req   = 0;
    int         m_beats = 0;

    logic       obs_req, obs_valid, obs_last, obs_ready;
    logic [7:0] obs_data;
    logic [2:0] obs_level;
    logic [7:0] beat_d[$];
    logic       beat_l[$];

    typedef struct {
        logic       r, iv;
        logic [7:0] d;
        logic       g;
        logic       e_req, e_valid, e_last;
        logic [7:0] e_data;
        logic [2:0] e_level;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, iv, input logic [7:0] d, input logic g,
                                input logic er, ev, el, input logic [7:0] ed,
                                input logic [2:0] elv);
        vec_t v;
        v.r = r; v.iv = iv; v.d = d; v.g = g;
        v.e_req = er; v.e_valid = ev; v.e_last = el; v.e_data = ed; v.e_level = elv;
        return v;
    endfunction

    task automatic step(input logic r, input logic iv, input logic [7:0] d, input logic g);
        logic e_ready, e_valid, e_last;
        logic [7:0] e_data;
        int e_level;
        rst = r; in_valid = iv; in_data = d; grant = g;
        if (!r) begin
            mq.delete();
            m_req   = 0;
            m_beats = 0;
        end
        e_level = mq.size();
        e_ready = (mq.size() < DEPTH);
        e_valid = m_req && g;
        e_last  = e_valid && (m_beats == BURST - 1 || mq.size() == 1);
        e_data  = (mq.size() != 0) ? mq[0] : 8'h00;
        @(negedge clk);
        obs_req = req; obs_valid = bus_valid; obs_last = bus_last;
        obs_ready = in_ready; obs_data = bus_data; obs_level = level;
        chk("m_req", 32'(obs_req), 32'(m_req));
        chk("m_valid", 32'(obs_valid), 32'(e_valid));
        chk("m_last", 32'(obs_last), 32'(e_last));
        chk("m_ready", 32'(obs_ready), 32'(e_ready));
        chk("m_level", 32'(obs_level), 32'(e_level));
        if (e_valid) chk("m_data", 32'(obs_data), 32'(e_data));
        if (obs_valid === 1'b1) begin
            beat_d.push_back(obs_data);
            beat_l.push_back(obs_last);
        end
        @(posedge clk);
        if (r) begin
            int sz0;
            sz0 = mq.size();
            if (e_valid) void'(mq.pop_front());
            if (iv && e_ready) mq.push_back(d);
            if (m_req) begin
                if (e_last) m_req = 0;
                else if (e_valid) m_beats++;
            end else if (sz0 != 0) begin
                m_req   = 1;
                m_beats = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        beat_d.delete();
        beat_l.delete();
    endtask

    initial begin
        logic [7:0] w;
        int idx, cnt, lvl_hold;
        bit pend;
        rst = 0; in_valid = 0; in_data = '0; grant = 0;
        @(posedge clk);
        #1;

        // Reset and short burst from a fixed vector table
        tbl[0]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        tbl[1]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        for (int i = 2; i < 7; i++) tbl[i] = mk(1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        tbl[7]  = mk(1, 1, 8'h11, 0, 0, 0, 0, 8'h00, 0);
        tbl[8]  = mk(1, 1, 8'h22, 0, 0, 0, 0, 8'h00, 1);
        tbl[9]  = mk(1, 1, 8'h33, 0, 1, 0, 0, 8'h00, 2);
        tbl[10] = mk(1, 0, 8'h00, 1, 1, 1, 0, 8'h11, 3);
        tbl[11] = mk(1, 0, 8'h00, 1, 1, 1, 0, 8'h22, 2);
        tbl[12] = mk(1, 0, 8'h00, 1, 1, 1, 1, 8'h33, 1);
        tbl[13] = mk(1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        tbl[14] = mk(1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].g);
            chk("t_req", 32'(obs_req), 32'(tbl[i].e_req));
            chk("t_valid", 32'(obs_valid), 32'(tbl[i].e_valid));
            chk("t_last", 32'(obs_last), 32'(tbl[i].e_last));
            chk("t_level", 32'(obs_level), 32'(tbl[i].e_level));
            chk("t_ready", 32'(obs_ready), 32'(tbl[i].e_level != 3'd4));
            if (tbl[i].e_valid) chk("t_data", 32'(obs_data), 32'(tbl[i].e_data));
        end

        // Burst split: six words, keep offering while grant is high
        do_reset();
        idx = 1;
        cnt = 0;
        while (beat_d.size() < 6 && cnt < 40) begin
            w = 8'(idx);
            step(1, idx <= 6, w, cnt >= 4);
            if (idx <= 6 && obs_ready) idx++;
            cnt++;
        end
        chk("split_n", beat_d.size(), 6);
        for (int i = 0; i < beat_d.size() && i < 6; i++) begin
            chk("split_data", 32'(beat_d[i]), 32'(i + 1));
            chk("split_last", 32'(beat_l[i]), 32'(i == 3 || i == 5));
        end

        // Intermittent grant, req must stay asserted across the holes
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 8'hA0 + 8'(i), 0);
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 8'h00, (i % 2) == 0);
            if (obs_req) cnt++;
            chk("int_level", 32'(obs_level), 32'(4 - (i + 1) / 2));
        end
        chk("int_req_held", cnt, 7);
        chk("int_n", beat_d.size(), 4);
        for (int i = 0; i < beat_d.size() && i < 4; i++) begin
            chk("int_data", 32'(beat_d[i]), 32'(8'hA0 + 8'(i)));
            chk("int_last", 32'(beat_l[i]), 32'(i == 3));
        end

        // Full FIFO: fifth word refused, then accepted alongside a pop
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 8'hC0 + 8'(i), 0);
        step(1, 1, 8'hC4, 0);
        chk("full_ready", 32'(obs_ready), 0);
        chk("full_level", 32'(obs_level), 4);
        idx = 0;
        cnt = 0;
        pend = 0;
        lvl_hold = 0;
        while (beat_d.size() < 5 && cnt < 30) begin
            step(1, idx == 0, 8'hC4, 1);
            if (pend) chk("full_level_hold", 32'(obs_level), lvl_hold);
            pend = 0;
            if (idx == 0 && obs_ready) begin
                idx = 1;
                if (obs_valid) begin
                    pend = 1;
                    lvl_hold = obs_level;
                end
            end
            cnt++;
        end
        chk("full_n", beat_d.size(), 5);
        for (int i = 0; i < beat_d.size() && i < 5; i++)
            chk("full_data", 32'(beat_d[i]), 32'(8'hC0 + 8'(i)));

        // Reset in the middle of a burst
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 8'hE0 + 8'(i), 0);
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        chk("rst_req", 32'(obs_req), 0);
        chk("rst_valid", 32'(obs_valid), 0);
        chk("rst_last", 32'(obs_last), 0);
        chk("rst_beats", beat_d.size(), 2);
        for (int i = 0; i < beat_l.size(); i++) chk("rst_nolast", 32'(beat_l[i]), 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 8'h00, 1);
            chk("post_req", 32'(obs_req), 0);
            chk("post_level", 32'(obs_level), 0);
        end
        step(1, 1, 8'h5A, 0);
        step(1, 0, 8'h00, 0);
        chk("lat_req0", 32'(obs_req), 0);
        step(1, 0, 8'h00, 1);
        chk("lat_req1", 32'(obs_req), 1);
        chk("lat_data", 32'(obs_data), 32'h5A);

        // Random traffic against the reference queue
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) != 0, $urandom_range(0, 2) != 0,
                 8'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
